// File: rtl/mmss_timer.sv
// mmss_timer: MM:SS stopwatch / countdown timer with prescaler and
// four active-low 7-segment digit outputs (segment a = index 0).
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | stopped, prescaler cleared, waiting for start
// S_RUN   | prescaler running, value counts on each tick
// S_PAUSE | frozen value and prescaler, waiting for resume
// S_DONE  | countdown reached 00:00, waits for clear/load
module mmss_timer #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1,
  parameter int MAX_MIN = 59
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       start_stop,
  input  logic       mode_down,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [0:6] hex_mh,
  output logic [0:6] hex_ml,
  output logic [0:6] hex_sh,
  output logic [0:6] hex_sl,
  output logic       running,
  output logic       rollover,
  output logic       done
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(DIV - 1);
  localparam logic [3:0] MAX_HI = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_LO = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    min_hi_q, min_hi_d, min_lo_q, min_lo_d;
  logic [3:0]    sec_hi_q, sec_hi_d, sec_lo_q, sec_lo_d;
  logic          mode_q, mode_d;
  logic          ss_q;
  logic          rollover_q, rollover_d;

  logic          ss_event;
  logic          tick;
  logic          is_zero;
  logic [3:0]    ld_mh, ld_ml, ld_sh, ld_sl;
  logic [6:0]    ld_min_val;

  function automatic logic [3:0] sat_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [0:6] seg7(input logic [3:0] d);
    logic [0:6] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign ss_event = start_stop & ~ss_q;
  assign is_zero  = (min_hi_q == 4'd0) && (min_lo_q == 4'd0) &&
                    (sec_hi_q == 4'd0) && (sec_lo_q == 4'd0);

  // Preset saturation: clamp each digit to 9, then clamp the field values.
  always_comb begin
    ld_mh      = sat_digit(load_min[7:4]);
    ld_ml      = sat_digit(load_min[3:0]);
    ld_sh      = sat_digit(load_sec[7:4]);
    ld_sl      = sat_digit(load_sec[3:0]);
    ld_min_val = 7'(ld_mh) * 7'd10 + 7'(ld_ml);
    if (ld_min_val > 7'(MAX_MIN)) begin
      ld_mh = MAX_HI;
      ld_ml = MAX_LO;
    end
    if (ld_sh > 4'd5) begin
      ld_sh = 4'd5;
      ld_sl = 4'd9;
    end
  end

  // Next-state, prescaler and BCD counter logic; priority clear > load > event > tick.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    mode_d     = mode_q;
    min_hi_d   = min_hi_q;
    min_lo_d   = min_lo_q;
    sec_hi_d   = sec_hi_q;
    sec_lo_d   = sec_lo_q;
    rollover_d = 1'b0;
    tick       = 1'b0;

    if (state_q == S_RUN) begin
      if (presc_q == PRESC_TOP) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    if (clear) begin
      state_d  = S_IDLE;
      presc_d  = '0;
      min_hi_d = 4'd0;
      min_lo_d = 4'd0;
      sec_hi_d = 4'd0;
      sec_lo_d = 4'd0;
    end else if (load && (state_q != S_RUN)) begin
      presc_d  = '0;
      min_hi_d = ld_mh;
      min_lo_d = ld_ml;
      sec_hi_d = ld_sh;
      sec_lo_d = ld_sl;
      if (state_q == S_DONE) state_d = S_IDLE;
    end else begin
      if (tick) begin
        if (!mode_q) begin
          if (sec_lo_q != 4'd9) begin
            sec_lo_d = sec_lo_q + 4'd1;
          end else begin
            sec_lo_d = 4'd0;
            if (sec_hi_q != 4'd5) begin
              sec_hi_d = sec_hi_q + 4'd1;
            end else begin
              sec_hi_d = 4'd0;
              if ((min_hi_q == MAX_HI) && (min_lo_q == MAX_LO)) begin
                min_hi_d   = 4'd0;
                min_lo_d   = 4'd0;
                rollover_d = 1'b1;
              end else if (min_lo_q != 4'd9) begin
                min_lo_d = min_lo_q + 4'd1;
              end else begin
                min_lo_d = 4'd0;
                min_hi_d = min_hi_q + 4'd1;
              end
            end
          end
        end else if (is_zero) begin
          // Defensive: a down-count never runs at 00:00, but never wrap if it does.
          state_d = S_DONE;
        end else begin
          if ((min_hi_q == 4'd0) && (min_lo_q == 4'd0) &&
              (sec_hi_q == 4'd0) && (sec_lo_q == 4'd1)) begin
            state_d = S_DONE;
          end
          if (sec_lo_q != 4'd0) begin
            sec_lo_d = sec_lo_q - 4'd1;
          end else begin
            sec_lo_d = 4'd9;
            if (sec_hi_q != 4'd0) begin
              sec_hi_d = sec_hi_q - 4'd1;
            end else begin
              sec_hi_d = 4'd5;
              if (min_lo_q != 4'd0) begin
                min_lo_d = min_lo_q - 4'd1;
              end else begin
                min_lo_d = 4'd9;
                min_hi_d = min_hi_q - 4'd1;
              end
            end
          end
        end
      end

      if (ss_event) begin
        case (state_q)
          S_IDLE, S_PAUSE: begin
            mode_d  = mode_down;
            state_d = (mode_down && is_zero) ? S_DONE : S_RUN;
          end
          // A pause on the same cycle as the final down tick wins over DONE.
          S_RUN:   state_d = S_PAUSE;
          default: ;
        endcase
      end
    end

    if ((state_d == S_IDLE) || (state_d == S_DONE)) presc_d = '0;
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      mode_q     <= 1'b0;
      min_hi_q   <= 4'd0;
      min_lo_q   <= 4'd0;
      sec_hi_q   <= 4'd0;
      sec_lo_q   <= 4'd0;
      ss_q       <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      mode_q     <= mode_d;
      min_hi_q   <= min_hi_d;
      min_lo_q   <= min_lo_d;
      sec_hi_q   <= sec_hi_d;
      sec_lo_q   <= sec_lo_d;
      ss_q       <= start_stop;
      rollover_q <= rollover_d;
    end
  end

  // Output decode from registered state and digits.
  always_comb begin
    min_bcd  = {min_hi_q, min_lo_q};
    sec_bcd  = {sec_hi_q, sec_lo_q};
    hex_mh   = seg7(min_hi_q);
    hex_ml   = seg7(min_lo_q);
    hex_sh   = seg7(sec_hi_q);
    hex_sl   = seg7(sec_lo_q);
    running  = (state_q == S_RUN);
    done     = (state_q == S_DONE);
    rollover = rollover_q;
  end

endmodule

// File: tb/tb_mmss_timer.sv
// Testbench for mmss_timer: directed scenarios plus random stimulus,
// checked against a total-seconds reference model.
module tb_mmss_timer;

  localparam int DIV  = 10;
  localparam int MAXM = 59;
  localparam int MAXV = (MAXM + 1) * 60;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       start_stop = 1'b0;
  logic       mode_down = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_min = 8'h00;
  logic [7:0] load_sec = 8'h00;
  logic [7:0] min_bcd, sec_bcd;
  logic [0:6] hex_mh, hex_ml, hex_sh, hex_sl;
  logic       running, rollover, done;

  int n_vec = 0;
  int n_err = 0;

  int m_st, m_v, m_cnt, m_mode, m_ss_prev, m_roll;

  mmss_timer #(.CLK_HZ(10), .TICK_HZ(1), .MAX_MIN(MAXM)) dut (
    .clock(clock), .reset(reset), .clear(clear), .start_stop(start_stop),
    .mode_down(mode_down), .load(load), .load_min(load_min), .load_sec(load_sec),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .hex_mh(hex_mh), .hex_ml(hex_ml), .hex_sh(hex_sh), .hex_sl(hex_sl),
    .running(running), .rollover(rollover), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int sat_field(input logic [7:0] b, input int lim);
    int hi, lo, v;
    hi = int'(b[7:4]);
    lo = int'(b[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    v = hi * 10 + lo;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_v = 0; m_cnt = 0; m_mode = 0; m_ss_prev = 0; m_roll = 0;
  endtask

  task automatic model_step();
    int st0, ev, tk;
    if (reset) begin
      model_reset();
      return;
    end
    st0 = m_st;
    ev = (start_stop && !m_ss_prev) ? 1 : 0;
    m_ss_prev = start_stop ? 1 : 0;
    tk = (st0 == M_RUN && m_cnt == DIV - 1) ? 1 : 0;
    if (st0 == M_RUN) m_cnt = (m_cnt + 1) % DIV;
    m_roll = 0;
    if (clear) begin
      m_st = M_IDLE; m_v = 0; m_cnt = 0;
    end else if (load && st0 != M_RUN) begin
      m_v = sat_field(load_min, MAXM) * 60 + sat_field(load_sec, 59);
      m_cnt = 0;
      if (st0 == M_DONE) m_st = M_IDLE;
    end else begin
      if (tk) begin
        if (m_mode == 0) begin
          m_v = m_v + 1;
          if (m_v == MAXV) begin m_v = 0; m_roll = 1; end
        end else begin
          if (m_v > 0) m_v = m_v - 1;
          if (m_v == 0) m_st = M_DONE;
        end
      end
      if (ev) begin
        if (st0 == M_IDLE || st0 == M_PAUSE) begin
          m_mode = mode_down ? 1 : 0;
          m_st = (mode_down && m_v == 0) ? M_DONE : M_RUN;
        end else if (st0 == M_RUN) begin
          m_st = M_PAUSE;
        end
      end
    end
    if (m_st == M_IDLE || m_st == M_DONE) m_cnt = 0;
  endtask

  task automatic check_all();
    int mm, ss;
    mm = m_v / 60;
    ss = m_v % 60;
    chk("min_bcd", 32'(min_bcd), 32'(((mm / 10) << 4) | (mm % 10)));
    chk("sec_bcd", 32'(sec_bcd), 32'(((ss / 10) << 4) | (ss % 10)));
    chk("running", 32'(running), 32'(m_st == M_RUN));
    chk("done", 32'(done), 32'(m_st == M_DONE));
    chk("rollover", 32'(rollover), 32'(m_roll));
    chk("hex_mh", {25'b0, hex_mh}, {25'b0, seg_ref(mm / 10)});
    chk("hex_ml", {25'b0, hex_ml}, {25'b0, seg_ref(mm % 10)});
    chk("hex_sh", {25'b0, hex_sh}, {25'b0, seg_ref(ss / 10)});
    chk("hex_sl", {25'b0, hex_sl}, {25'b0, seg_ref(ss % 10)});
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; cycle();
    start_stop = 1'b0; cycle();
  endtask

  task automatic do_clear();
    clear = 1'b1; cycle();
    clear = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] mn, input logic [7:0] sc);
    load = 1'b1; load_min = mn; load_sec = sc; cycle();
    load = 1'b0;
  endtask

  initial begin
    model_reset();
    run(2);
    chk("rst_hex_sl", {25'b0, hex_sl}, 32'h01);
    chk("rst_hex_mh", {25'b0, hex_mh}, 32'h01);
    reset = 1'b0;
    run(2);

    // Up-count: ten ticks from 00:00.
    mode_down = 1'b0;
    pulse_ss();
    run(99);
    chk("tp1_sec", 32'(sec_bcd), 32'h10);
    chk("tp1_run", 32'(running), 32'd1);

    // Wrap at MAX_MIN:59.
    do_clear();
    do_load(8'h59, 8'h58);
    pulse_ss();
    run(9);
    chk("wrap_pre", 32'({min_bcd, sec_bcd}), 32'h5959);
    run(10);
    chk("wrap_val", 32'({min_bcd, sec_bcd}), 32'h0000);
    chk("wrap_roll", 32'(rollover), 32'd1);
    run(1);
    chk("wrap_roll_off", 32'(rollover), 32'd0);
    chk("wrap_run", 32'(running), 32'd1);

    // Countdown from 01:00 to DONE.
    do_clear();
    do_load(8'h01, 8'h00);
    mode_down = 1'b1;
    pulse_ss();
    mode_down = 1'b0;
    run(9);
    chk("dn_first", 32'({min_bcd, sec_bcd}), 32'h0059);
    run(590);
    chk("dn_done", 32'(done), 32'd1);
    chk("dn_val", 32'({min_bcd, sec_bcd}), 32'h0000);
    pulse_ss();
    pulse_ss();
    chk("dn_ignore", 32'(done), 32'd1);
    do_clear();
    chk("dn_clear", 32'(done), 32'd0);

    // Down start at 00:00 goes straight to DONE.
    mode_down = 1'b1;
    pulse_ss();
    chk("dn_zero", 32'(done), 32'd1);
    do_clear();

    // Held start_stop gives one event; pause freezes; resume continues.
    mode_down = 1'b0;
    start_stop = 1'b1; run(50);
    chk("hold_run", 32'(running), 32'd1);
    start_stop = 1'b0; run(3);
    start_stop = 1'b1; cycle();
    chk("pause", 32'(running), 32'd0);
    run(20);
    start_stop = 1'b0; cycle();
    start_stop = 1'b1; cycle();
    start_stop = 1'b0;
    run(15);

    // Saturating load, then load ignored in RUN.
    do_clear();
    do_load(8'h7A, 8'h75);
    chk("sat_val", 32'({min_bcd, sec_bcd}), 32'h5959);
    chk("sat_hex_sl", {25'b0, hex_sl}, 32'h04);
    pulse_ss();
    do_load(8'h00, 8'h00);
    chk("load_in_run", 32'(min_bcd), 32'h59);

    // Async reset mid-cycle while running at 12:34.
    do_clear();
    do_load(8'h12, 8'h34);
    pulse_ss();
    run(3);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_val", 32'({min_bcd, sec_bcd}), 32'h0000);
    chk("arst_run", 32'(running), 32'd0);
    chk("arst_hex", {4'b0, hex_mh, hex_ml, hex_sh, hex_sl}, {4'b0, {4{7'b0000001}}});
    model_reset();
    cycle();
    reset = 1'b0;
    run(2);

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      clear = ($urandom_range(0, 149) == 0);
      load  = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0: load_min = 8'h00;
        1: load_min = 8'h59;
        default: load_min = 8'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 4))
        0: load_sec = 8'h01;
        1: load_sec = 8'h58;
        2: load_sec = 8'h59;
        default: load_sec = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 11) == 0) start_stop = ~start_stop;
      if ($urandom_range(0, 9) == 0) mode_down = ~mode_down;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmss_timer.md
Name: mmss_timer

Overview:
- Parametrised minutes:seconds timer and stopwatch with four 7-segment digit outputs (MM:SS).
- Generalises the 00–59 seconds counter. Adds a configurable prescaler, a minutes field with configurable maximum, up/down mode, start/pause control, preset load, rollover and done flags.
- Sits between the board clock and the HEX displays. Control inputs come from externally debounced switches and keys.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1, count rate in Hz. CLK_HZ/TICK_HZ must be an integer of at least 2.
- MAX_MIN, 59, highest minutes value, range 1..99.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- clear  in  1  synchronous; return to IDLE at 00:00
- start_stop  in  1  level input; a rising edge toggles run/pause
- mode_down  in  1  0 = count up (stopwatch), 1 = count down (timer); sampled only on entry to RUN
- load  in  1  synchronous preset strobe
- load_min  in  8  BCD preset minutes {tens, ones}
- load_sec  in  8  BCD preset seconds {tens, ones}
- min_bcd  out  8  current minutes, BCD
- sec_bcd  out  8  current seconds, BCD
- hex_mh, hex_ml, hex_sh, hex_sl  out  [0:6] each  segment outputs, active-low, segment a = bit 0
- running  out  1  high in RUN
- rollover  out  1  one-cycle pulse on up-count wrap
- done  out  1  high in DONE

Behaviour:
- Reset values:
  - state IDLE, all digits 0, prescaler 0, start_stop edge register 0.
  - running = 0, rollover = 0, done = 0.
  - All hex outputs show "0" (7'b0000001).
- Prescaler:
  - Width is $clog2(CLK_HZ/TICK_HZ).
  - Increments only in RUN. At CLK_HZ/TICK_HZ-1 it wraps to 0 and generates an internal one-cycle tick.
  - Holds its value in PAUSE. Clears to 0 in IDLE and DONE, and on clear or load.
- Edge detect: start_stop is registered once. The event is `start_stop & ~start_stop_q`. A held-high level produces one event only.
- Captured mode: mode_down is captured into an internal mode register on every transition into RUN. Changing mode_down mid-run has no effect.
- States:
  - IDLE to RUN on a start_stop event.
  - RUN to PAUSE on a start_stop event.
  - PAUSE to RUN on a start_stop event.
  - RUN to DONE when the down-count tick takes the value from 00:01 to 00:00.
  - DONE to IDLE on clear. A start_stop event in DONE is ignored.
  - Any state to IDLE at 00:00 on clear.
  - Down-count start at 00:00: a start_stop event in IDLE or PAUSE with mode_down = 1 and value 00:00 goes directly to DONE.
- Up count on tick:
  - sec_lo 9 becomes 0 and carries to sec_hi.
  - sec_hi 5 with carry becomes 0 and carries to minutes.
  - Minutes count BCD up to MAX_MIN.
  - At MAX_MIN:59 the value becomes 00:00, rollover pulses for that cycle, and the state stays RUN.
- Down count on tick:
  - Symmetric borrow: sec_lo 0 becomes 9; sec_hi 0 with borrow becomes 5; minutes decrement in BCD.
  - On reaching 00:00 the next state is DONE; the value stays 00:00 and no wrap occurs.
- Load:
  - Accepted in IDLE, PAUSE and DONE. Ignored in RUN.
  - Sets min_bcd/sec_bcd from load_min/load_sec on the next edge.
  - From DONE, state becomes IDLE.
  - Invalid inputs saturate:
    - Any BCD digit above 9 is treated as 9.
    - Seconds above 59 become 59.
    - Minutes above MAX_MIN become MAX_MIN.
- Priority within one cycle: reset > clear > load > start_stop event > tick.
  - If a tick and a start_stop pause coincide, the tick is applied and then the state becomes PAUSE.
- Outputs:
  - running = (state == RUN), registered with state.
  - done = (state == DONE).
  - Hex outputs decode digits combinationally from the registered digits. Digits 0–9 only; other codes show blank (7'b1111111).
- Reset mid-run returns to the reset values immediately, with no tick generated.

Test Plan:
- CLK_HZ=10, TICK_HZ=1, MAX_MIN=59. Release reset, pulse start_stop with mode_down=0 -> tick every 10 cycles; after 10 ticks sec_bcd=8'h10, running=1.
- Load 59:58 in IDLE, start up-count -> 59:59 after one tick; next tick 00:00 with rollover high exactly one cycle; running stays 1.
- Load 01:00, mode_down=1, start -> next tick 00:59; after 60 ticks total 00:00, done=1, running=0; further start_stop events ignored; clear -> IDLE, done=0.
- Hold start_stop high 50 cycles from IDLE -> single transition to RUN. Second rising edge -> PAUSE, value and prescaler frozen. Third edge -> resumes, next tick arrives after the remaining prescaler cycles.
- Load min=8'h7A, sec=8'h75 -> min_bcd=8'h59 and sec_bcd=8'h59 (saturated); hex_sl=7'b0000100 ("9"). Load asserted in RUN -> value unchanged.
- Assert reset asynchronously mid-cycle while in RUN at 12:34 -> outputs go to 00:00, running=0, all hex outputs "0" before the next clock edge.
